ram128x8_arbiter: RTL and testbench

Two-requester round-robin arbiter and init sequencer for the shared 128x8 synchronous-read RAM in the CoreABC subsystem. After reset it optionally fills every RAM word with INIT_VALUE. It then grants one access per cycle, either a read or a write, to requester 0 or 1, and returns read data with a valid strobe one cycle after the grant.

---
 rtl/ram128x8_arbiter_pkg.sv | 11 +
 rtl/ram128x8_arbiter_if.sv | 32 +++
 rtl/ram128x8_rr_arb2.sv | 34 +++
 rtl/ram128x8_arbiter.sv | 112 +++++++++++
 tb/tb_ram128x8_arbiter.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/ram128x8_arbiter_pkg.sv
// Shared types and sizes for the 128x8 RAM arbiter and init sequencer.
package ram128x8_arb_pkg;
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int RAM_AW    = 7;
  localparam int RAM_DW    = 8;
  localparam int RAM_DEPTH = 128;
endpackage

// File: rtl/ram128x8_arbiter_if.sv
// Requester and RAM-side signals of the arbiter; slave = arbiter view, master = requesters/RAM view.
interface ram128x8_arbiter_if;
  import ram128x8_arb_pkg::*;

  // Handshake: REQn/WEn/ADDRn/WDATAn held stable until GNTn is sampled high; one access per GNTn cycle,
  // read data on RDATA while RVALIDn is high one cycle after a read grant.
  logic              REQ0, WE0, GNT0, RVALID0;
  logic [RAM_AW-1:0] ADDR0;
  logic [RAM_DW-1:0] WDATA0;
  logic              REQ1, WE1, GNT1, RVALID1;
  logic [RAM_AW-1:0] ADDR1;
  logic [RAM_DW-1:0] WDATA1;
  logic [RAM_DW-1:0] RDATA;
  logic              INIT_DONE;
  logic [RAM_DW-1:0] RAM_WD;
  logic [RAM_AW-1:0] RAM_WADDR;
  logic [RAM_AW-1:0] RAM_RADDR;
  logic              RAM_WEN;
  logic [RAM_DW-1:0] RAM_RD;

  modport slave (
    input  REQ0, WE0, ADDR0, WDATA0, REQ1, WE1, ADDR1, WDATA1, RAM_RD,
    output GNT0, RVALID0, GNT1, RVALID1, RDATA, INIT_DONE,
           RAM_WD, RAM_WADDR, RAM_RADDR, RAM_WEN
  );

  modport master (
    output REQ0, WE0, ADDR0, WDATA0, REQ1, WE1, ADDR1, WDATA1, RAM_RD,
    input  GNT0, RVALID0, GNT1, RVALID1, RDATA, INIT_DONE,
           RAM_WD, RAM_WADDR, RAM_RADDR, RAM_WEN
  );
endinterface

// File: rtl/ram128x8_rr_arb2.sv
// Two-way round-robin arbiter: pointer register plus same-cycle combinational grant.
module ram128x8_rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o,
  output logic       ptr_o
);
  logic ptr_q, ptr_d;

  always_comb begin
    gnt_o = 2'b00;
    ptr_d = ptr_q;
    if (en_i) begin
      case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = ptr_q ? 2'b10 : 2'b01;
        default: gnt_o = 2'b00;
      endcase
    end
    // The pointer always favours whichever requester was not just served.
    if (gnt_o[0])      ptr_d = 1'b1;
    else if (gnt_o[1]) ptr_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) ptr_q <= 1'b0;
    else       ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;
endmodule

// File: rtl/ram128x8_arbiter.sv
// Init-fill FSM, RAM port muxing and read-valid strobes around the round-robin arbiter.
module ram128x8_arbiter
  import ram128x8_arb_pkg::*;
#(
  parameter bit                INIT_ENABLE = 1'b1,
  parameter logic [RAM_DW-1:0] INIT_VALUE  = 8'h00,
  parameter int                DEPTH       = RAM_DEPTH
) (
  input  logic                PCLK,
  input  logic                RESET,
  ram128x8_arbiter_if.slave   bus,
  output state_e              dbg_state_o
);
  localparam logic [RAM_AW-1:0] LAST_ADDR = RAM_AW'(DEPTH - 1);
  localparam state_e            RST_STATE = INIT_ENABLE ? ST_INIT : ST_RUN;

  state_e            state_q, state_d;
  logic [RAM_AW-1:0] cnt_q, cnt_d;
  logic              init_done_q, init_done_d;
  logic              rvalid0_q, rvalid1_q;
  logic              arb_en;
  logic [1:0]        gnt;
  logic              arb_ptr;
  logic              ram_wen;
  logic [RAM_AW-1:0] ram_waddr, ram_raddr;
  logic [RAM_DW-1:0] ram_wd;

  // Grants are gated by RESET so a reset cycle can never start an access.
  ram128x8_rr_arb2 u_arb (
    .clk_i (PCLK),
    .rst_i (RESET),
    .en_i  (arb_en),
    .req_i ({bus.REQ1, bus.REQ0}),
    .gnt_o (gnt),
    .ptr_o (arb_ptr)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    arb_en      = 1'b0;
    ram_wen     = 1'b0;
    ram_waddr   = '0;
    ram_raddr   = '0;
    ram_wd      = '0;
    case (state_q)
      ST_INIT: begin
        ram_wen   = 1'b1;
        ram_waddr = cnt_q;
        ram_wd    = INIT_VALUE;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d     = ST_RUN;
          init_done_d = 1'b1;
        end
      end
      ST_RUN: begin
        arb_en = ~RESET;
        if (gnt[0]) begin
          if (bus.WE0) begin
            ram_wen   = 1'b1;
            ram_waddr = bus.ADDR0;
            ram_wd    = bus.WDATA0;
          end else begin
            ram_raddr = bus.ADDR0;
          end
        end else if (gnt[1]) begin
          if (bus.WE1) begin
            ram_wen   = 1'b1;
            ram_waddr = bus.ADDR1;
            ram_wd    = bus.WDATA1;
          end else begin
            ram_raddr = bus.ADDR1;
          end
        end
      end
      default: state_d = RST_STATE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (RESET) begin
      state_q     <= RST_STATE;
      cnt_q       <= '0;
      init_done_q <= ~INIT_ENABLE;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
      rvalid0_q   <= gnt[0] & ~bus.WE0;
      rvalid1_q   <= gnt[1] & ~bus.WE1;
    end
  end

  assign bus.GNT0      = gnt[0];
  assign bus.GNT1      = gnt[1];
  assign bus.RVALID0   = rvalid0_q;
  assign bus.RVALID1   = rvalid1_q;
  assign bus.RDATA     = bus.RAM_RD;
  assign bus.INIT_DONE = init_done_q;
  assign bus.RAM_WEN   = ram_wen;
  assign bus.RAM_WADDR = ram_waddr;
  assign bus.RAM_RADDR = ram_raddr;
  assign bus.RAM_WD    = ram_wd;
  assign dbg_state_o   = state_q;

  logic unused_ptr;
  assign unused_ptr = arb_ptr;
endmodule

// File: tb/tb_ram128x8_arbiter.sv
// Directed bench: fill, single-port latency, contention, held-off requests, resets, and no-init variant.
module tb_ram128x8_arbiter;
  import ram128x8_arb_pkg::*;

  logic   PCLK;
  logic   RESET;
  state_e st_a, st_b;
  int     n_cmp;
  int     n_fail;

  ram128x8_arbiter_if bus_a ();
  ram128x8_arbiter_if bus_b ();

  ram128x8_arbiter #(.INIT_ENABLE(1'b1), .INIT_VALUE(8'hA5), .DEPTH(128)) dut_a (
    .PCLK(PCLK), .RESET(RESET), .bus(bus_a.slave), .dbg_state_o(st_a)
  );
  ram128x8_arbiter #(.INIT_ENABLE(1'b0), .INIT_VALUE(8'h00), .DEPTH(128)) dut_b (
    .PCLK(PCLK), .RESET(RESET), .bus(bus_b.slave), .dbg_state_o(st_b)
  );

  // clock / reset
  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // synchronous-read RAM models
  logic [7:0] mem_a [128];
  logic [7:0] mem_b [128];
  always @(posedge PCLK) begin
    if (bus_a.RAM_WEN) mem_a[bus_a.RAM_WADDR] <= bus_a.RAM_WD;
    bus_a.RAM_RD <= mem_a[bus_a.RAM_RADDR];
    if (bus_b.RAM_WEN) mem_b[bus_b.RAM_WADDR] <= bus_b.RAM_WD;
    bus_b.RAM_RD <= mem_b[bus_b.RAM_RADDR];
  end

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic idle_a();
    bus_a.REQ0 = 0; bus_a.WE0 = 0; bus_a.ADDR0 = '0; bus_a.WDATA0 = '0;
    bus_a.REQ1 = 0; bus_a.WE1 = 0; bus_a.ADDR1 = '0; bus_a.WDATA1 = '0;
  endtask

  task automatic idle_b();
    bus_b.REQ0 = 0; bus_b.WE0 = 0; bus_b.ADDR0 = '0; bus_b.WDATA0 = '0;
    bus_b.REQ1 = 0; bus_b.WE1 = 0; bus_b.ADDR1 = '0; bus_b.WDATA1 = '0;
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    RESET = 1'b1;
    idle_a(); idle_b();
    tick(); tick();

    // reset values
    chk("rst_a_init_done", bus_a.INIT_DONE, 0);
    chk("rst_a_rvalid", {bus_a.RVALID1, bus_a.RVALID0}, 0);
    chk("rst_a_state", st_a, ST_INIT);
    chk("rst_b_init_done", bus_b.INIT_DONE, 1);
    chk("rst_b_rvalid", {bus_b.RVALID1, bus_b.RVALID0}, 0);

    RESET = 1'b0;
    bus_b.REQ1 = 1; bus_b.WE1 = 0; bus_b.ADDR1 = 7'h05;

    // fill on A; no-init B serves REQ1 immediately
    for (int i = 0; i < 128; i++) begin
      if (i == 5) begin bus_a.REQ1 = 1; bus_a.WE1 = 0; bus_a.ADDR1 = 7'h55; end
      if (i == 1) bus_b.REQ1 = 0;
      #1;
      chk("fill_wen", bus_a.RAM_WEN, 1);
      chk("fill_waddr", bus_a.RAM_WADDR, i);
      chk("fill_wd", bus_a.RAM_WD, 8'hA5);
      chk("fill_raddr", bus_a.RAM_RADDR, 0);
      chk("fill_init_done", bus_a.INIT_DONE, 0);
      chk("fill_no_gnt", {bus_a.GNT1, bus_a.GNT0}, 0);
      if (i == 0) chk("b_gnt1_first", {bus_b.GNT1, bus_b.GNT0}, 2'b10);
      if (i == 1) chk("b_rvalid1", {bus_b.RVALID1, bus_b.RVALID0}, 2'b10);
      if (i == 2) chk("b_rvalid1_pulse", {bus_b.RVALID1, bus_b.RVALID0}, 2'b00);
      tick();
    end

    // first RUN cycle: held REQ1 read of 0x55
    #1;
    chk("run_init_done", bus_a.INIT_DONE, 1);
    chk("run_state", st_a, ST_RUN);
    chk("held_gnt1", {bus_a.GNT1, bus_a.GNT0}, 2'b10);
    chk("held_wen", bus_a.RAM_WEN, 0);
    chk("held_raddr", bus_a.RAM_RADDR, 7'h55);
    tick();
    idle_a();
    #1;
    chk("held_rvalid1", {bus_a.RVALID1, bus_a.RVALID0}, 2'b10);
    chk("held_rdata", bus_a.RDATA, 8'hA5);

    // single-port write then read
    bus_a.REQ0 = 1; bus_a.WE0 = 1; bus_a.ADDR0 = 7'h10; bus_a.WDATA0 = 8'h3C;
    #1;
    chk("wr_gnt0", {bus_a.GNT1, bus_a.GNT0}, 2'b01);
    chk("wr_wen", bus_a.RAM_WEN, 1);
    chk("wr_waddr", bus_a.RAM_WADDR, 7'h10);
    chk("wr_wd", bus_a.RAM_WD, 8'h3C);
    tick();
    bus_a.WE0 = 0;
    #1;
    chk("wr_no_rvalid", {bus_a.RVALID1, bus_a.RVALID0}, 0);
    chk("rd_gnt0", {bus_a.GNT1, bus_a.GNT0}, 2'b01);
    chk("rd_wen", bus_a.RAM_WEN, 0);
    chk("rd_raddr", bus_a.RAM_RADDR, 7'h10);
    chk("rd_waddr_zero", bus_a.RAM_WADDR, 0);
    tick();
    idle_a();
    #1;
    chk("rd_rvalid0", {bus_a.RVALID1, bus_a.RVALID0}, 2'b01);
    chk("rd_rdata", bus_a.RDATA, 8'h3C);
    chk("idle_outputs", {bus_a.RAM_WEN, bus_a.RAM_WADDR, bus_a.RAM_RADDR, bus_a.RAM_WD}, 0);
    tick();
    #1;
    chk("rd_rvalid0_pulse", {bus_a.RVALID1, bus_a.RVALID0}, 0);

    // seed 0x01 and 0x02; leaves the pointer favouring requester 0
    bus_a.REQ0 = 1; bus_a.WE0 = 1; bus_a.ADDR0 = 7'h01; bus_a.WDATA0 = 8'h11;
    #1; chk("seed0_gnt", {bus_a.GNT1, bus_a.GNT0}, 2'b01);
    tick();
    idle_a();
    bus_a.REQ1 = 1; bus_a.WE1 = 1; bus_a.ADDR1 = 7'h02; bus_a.WDATA1 = 8'h22;
    #1; chk("seed1_gnt", {bus_a.GNT1, bus_a.GNT0}, 2'b10);
    tick();

    // contention: both read for 6 cycles
    bus_a.REQ0 = 1; bus_a.WE0 = 0; bus_a.ADDR0 = 7'h01;
    bus_a.REQ1 = 1; bus_a.WE1 = 0; bus_a.ADDR1 = 7'h02;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("cont_gnt", {bus_a.GNT1, bus_a.GNT0}, (k % 2 == 0) ? 2'b01 : 2'b10);
      chk("cont_raddr", bus_a.RAM_RADDR, (k % 2 == 0) ? 7'h01 : 7'h02);
      if (k > 0) begin
        chk("cont_rvalid", {bus_a.RVALID1, bus_a.RVALID0}, (k % 2 == 1) ? 2'b01 : 2'b10);
        chk("cont_rdata", bus_a.RDATA, (k % 2 == 1) ? 8'h11 : 8'h22);
      end
      tick();
    end
    idle_a();
    #1;
    chk("cont_last_rvalid", {bus_a.RVALID1, bus_a.RVALID0}, 2'b10);
    chk("cont_last_rdata", bus_a.RDATA, 8'h22);

    // reset with a pending B read: no grant, no RVALID
    RESET = 1'b1;
    bus_b.REQ0 = 1; bus_b.WE0 = 0; bus_b.ADDR0 = 7'h03;
    #1;
    chk("rst_b_no_gnt", {bus_b.GNT1, bus_b.GNT0}, 0);
    tick();
    idle_b();
    RESET = 1'b0;
    #1;
    chk("rst_b_rvalid_clr", {bus_b.RVALID1, bus_b.RVALID0}, 0);
    chk("rst_a_refill_done", bus_a.INIT_DONE, 0);

    // reset mid-fill at cnt=60
    for (int i = 0; i <= 60; i++) begin
      chk("mid_waddr", bus_a.RAM_WADDR, i);
      if (i == 60) RESET = 1'b1;
      tick();
    end
    RESET = 1'b0;
    for (int i = 0; i < 128; i++) begin
      chk("refill_waddr", bus_a.RAM_WADDR, i);
      chk("refill_wen", bus_a.RAM_WEN, 1);
      chk("refill_done_low", bus_a.INIT_DONE, 0);
      tick();
    end
    chk("refill_done", bus_a.INIT_DONE, 1);
    chk("refill_wen_off", bus_a.RAM_WEN, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
